// File: rtl/vslc_pkg.sv
// Shared types and constants for the VSLC debug stack-dump transmitter.
// Frames carry the 16-bit bit stack as two 8N1 bytes, low byte first.
package vslc_pkg;

   localparam int unsigned STACK_W = 16;
   localparam int unsigned BYTE_W  = 8;

   typedef enum logic [1:0] {
      StIdle,
      StStart,
      StData,
      StStop
   } dump_state_t;

endpackage

// File: rtl/vslc_baud_tick.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 and flags the last cycle of each period.
// Synchronous clear holds the count at zero so a new frame starts on a full period.
module vslc_baud_tick #(
   parameter int unsigned CLKS_PER_BIT = 4
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_clr,
   output logic o_tick
);

   localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

   logic [CNT_W-1:0] r_cnt;

   always_ff @(posedge i_clk) begin
      if (i_rst || i_clr) begin
         r_cnt <= '0;
      end else if (r_cnt == LAST) begin
         r_cnt <= '0;
      end else begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   assign o_tick = (r_cnt == LAST);

endmodule

// File: rtl/vslc_stack_dump.sv
// Debug transmitter: snapshots the VSLC bit stack on request and shifts it out as two
// back-to-back UART bytes (low byte first) on a single pin. All outputs are registered.
module vslc_stack_dump #(
   parameter int unsigned STACK_W      = 16,
   parameter int unsigned CLKS_PER_BIT = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [STACK_W-1:0] stack_in,
   input  logic               req,
   output logic               tx,
   output logic               busy,
   output logic               done
);

   import vslc_pkg::*;

   dump_state_t        r_state;
   dump_state_t        w_state_d;
   logic [STACK_W-1:0] r_shadow;
   logic               r_byte_sel;
   logic               w_byte_sel_d;
   logic [2:0]         r_idx;
   logic [2:0]         w_idx_d;
   logic [2:0]         w_idx_inc;
   logic               r_tx;
   logic               w_tx_d;
   logic               r_busy;
   logic               w_busy_d;
   logic               r_done;
   logic               w_done_d;
   logic               w_load;
   logic               w_tick;

   vslc_baud_tick #(
      .CLKS_PER_BIT (CLKS_PER_BIT)
   ) u_baud_tick (
      .i_clk  (clk),
      .i_rst  (rst),
      .i_clr  (r_state == StIdle),
      .o_tick (w_tick)
   );

   assign w_idx_inc = r_idx + 3'd1;

   // tx is computed for the state being entered so the pin changes on the slot boundary.
   always_comb begin
      w_state_d    = r_state;
      w_byte_sel_d = r_byte_sel;
      w_idx_d      = r_idx;
      w_tx_d       = r_tx;
      w_busy_d     = r_busy;
      w_done_d     = 1'b0;
      w_load       = 1'b0;
      unique case (r_state)
         StIdle: begin
            w_tx_d   = 1'b1;
            w_busy_d = 1'b0;
            if (req) begin
               w_load       = 1'b1;
               w_byte_sel_d = 1'b0;
               w_state_d    = StStart;
               w_tx_d       = 1'b0;
               w_busy_d     = 1'b1;
            end
         end
         StStart: begin
            if (w_tick) begin
               w_state_d = StData;
               w_idx_d   = 3'd0;
               w_tx_d    = r_shadow[{r_byte_sel, 3'd0}];
            end
         end
         StData: begin
            if (w_tick) begin
               if (r_idx == 3'd7) begin
                  w_state_d = StStop;
                  w_tx_d    = 1'b1;
               end else begin
                  w_idx_d = w_idx_inc;
                  w_tx_d  = r_shadow[{r_byte_sel, w_idx_inc}];
               end
            end
         end
         StStop: begin
            if (w_tick) begin
               if (!r_byte_sel) begin
                  // Second byte follows immediately, no idle bit between bytes.
                  w_byte_sel_d = 1'b1;
                  w_state_d    = StStart;
                  w_tx_d       = 1'b0;
               end else begin
                  w_state_d = StIdle;
                  w_tx_d    = 1'b1;
                  w_busy_d  = 1'b0;
                  w_done_d  = 1'b1;
               end
            end
         end
         default: w_state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= StIdle;
         r_shadow   <= '0;
         r_byte_sel <= 1'b0;
         r_idx      <= 3'd0;
         r_tx       <= 1'b1;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
      end else begin
         r_state    <= w_state_d;
         r_byte_sel <= w_byte_sel_d;
         r_idx      <= w_idx_d;
         r_tx       <= w_tx_d;
         r_busy     <= w_busy_d;
         r_done     <= w_done_d;
         if (w_load) begin
            r_shadow <= stack_in;
         end
      end
   end

   assign tx   = r_tx;
   assign busy = r_busy;
   assign done = r_done;

endmodule

// File: tb/tb_vslc_stack_dump.sv
// Bench for vslc_stack_dump: one instance at 4 clocks/bit, one at 1 clock/bit, checked
// every cycle against a frame-timeline model plus directed literal expectations.
module tb_vslc_stack_dump;

   logic        clk;
   logic        rst_v   [2];
   logic        req_v   [2];
   logic [15:0] stack_v [2];
   logic        tx_v    [2];
   logic        busy_v  [2];
   logic        done_v  [2];

   int n_cmp  = 0;
   int n_fail = 0;
   logic check_en = 1'b0;

   vslc_stack_dump #(
      .STACK_W      (16),
      .CLKS_PER_BIT (4)
   ) u_dut4 (
      .clk      (clk),
      .rst      (rst_v[0]),
      .stack_in (stack_v[0]),
      .req      (req_v[0]),
      .tx       (tx_v[0]),
      .busy     (busy_v[0]),
      .done     (done_v[0])
   );

   vslc_stack_dump #(
      .STACK_W      (16),
      .CLKS_PER_BIT (1)
   ) u_dut1 (
      .clk      (clk),
      .rst      (rst_v[1]),
      .stack_in (stack_v[1]),
      .req      (req_v[1]),
      .tx       (tx_v[1]),
      .busy     (busy_v[1]),
      .done     (done_v[1])
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
      n_cmp++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s: got %0h, want %0h (t=%0t)", name, got, want, $time);
      end
   endtask

   // Model: a frame is a 20-slot bit vector (slot 0 = first start bit) played at cpb clocks/slot.
   function automatic logic [19:0] make_frame(input logic [15:0] v);
      return {1'b1, v[15:8], 1'b0, 1'b1, v[7:0], 1'b0};
   endfunction

   function automatic int cpb_of(input int d);
      return (d == 0) ? 4 : 1;
   endfunction

   logic        m_act   [2];
   int          m_t     [2];
   logic        m_dn    [2];
   logic [19:0] m_frame [2];

   always @(posedge clk) begin
      for (int d = 0; d < 2; d++) begin
         if (rst_v[d]) begin
            m_act[d] <= 1'b0;
            m_dn[d]  <= 1'b0;
            m_t[d]   <= 0;
         end else if (m_act[d]) begin
            if (m_t[d] == 20 * cpb_of(d) - 1) begin
               m_act[d] <= 1'b0;
               m_dn[d]  <= 1'b1;
            end else begin
               m_t[d] <= m_t[d] + 1;
            end
         end else begin
            m_dn[d] <= 1'b0;
            if (req_v[d]) begin
               m_act[d]   <= 1'b1;
               m_t[d]     <= 0;
               m_frame[d] <= make_frame(stack_v[d]);
            end
         end
      end
   end

   always @(negedge clk) begin
      if (check_en) begin
         for (int d = 0; d < 2; d++) begin
            logic exp_tx;
            exp_tx = m_act[d] ? m_frame[d][m_t[d] / cpb_of(d)] : 1'b1;
            chk($sformatf("cyc dut%0d tx", d), 32'(tx_v[d]), 32'(exp_tx));
            chk($sformatf("cyc dut%0d busy", d), 32'(busy_v[d]), 32'(m_act[d]));
            chk($sformatf("cyc dut%0d done", d), 32'(done_v[d]), 32'(m_dn[d]));
         end
      end
   end

   // Drives one request on the 4-clk/bit DUT and records mid-slot tx samples for two frames.
   task automatic frame4(input logic [15:0] v0, input logic [15:0] v1, input int req_len,
                         input int req2_at, input int rst_at, input int ncyc,
                         output logic [19:0] bits, output logic [19:0] bits2,
                         output int nbusy, output int ndone, output int first_done);
      bits = '0; bits2 = '0; nbusy = 0; ndone = 0; first_done = 0;
      @(negedge clk);
      stack_v[0] = v0;
      req_v[0]   = 1'b1;
      for (int k = 1; k <= ncyc; k++) begin
         @(negedge clk);
         if (k % 4 == 2 && k / 4 < 20) bits[k / 4] = tx_v[0];
         if (k > 81 && (k - 81) % 4 == 2 && (k - 81) / 4 < 20) bits2[(k - 81) / 4] = tx_v[0];
         nbusy += int'(busy_v[0]);
         ndone += int'(done_v[0]);
         if (done_v[0] && first_done == 0) first_done = k;
         stack_v[0] = v1;
         req_v[0]   = (k < req_len) || (k == req2_at);
         rst_v[0]   = (k == rst_at);
      end
      req_v[0] = 1'b0;
      rst_v[0] = 1'b0;
   endtask

   initial begin
      logic [19:0] bits, bits2, seq1;
      int nbusy, ndone, first_done, done1;
      for (int d = 0; d < 2; d++) begin
         rst_v[d] = 1'b1; req_v[d] = 1'b0; stack_v[d] = '0;
      end
      @(negedge clk);
      check_en = 1'b1;
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         chk($sformatf("reset dut%0d tx", d), 32'(tx_v[d]), 32'd1);
         chk($sformatf("reset dut%0d busy", d), 32'(busy_v[d]), 32'd0);
         chk($sformatf("reset dut%0d done", d), 32'(done_v[d]), 32'd0);
         rst_v[d] = 1'b0;
      end
      repeat (3) @(negedge clk);

      // Basic frame
      frame4(16'hA5C3, 16'hA5C3, 1, 0, 0, 100, bits, bits2, nbusy, ndone, first_done);
      chk("basic slots", 32'(bits), 32'h000D2B86);
      chk("basic busy cycles", 32'(nbusy), 32'd80);
      chk("basic done cycle", 32'(first_done), 32'd81);
      chk("basic done count", 32'(ndone), 32'd1);

      // Snapshot isolation
      frame4(16'h0001, 16'hFFFF, 1, 0, 0, 100, bits, bits2, nbusy, ndone, first_done);
      chk("snap low byte", 32'(bits[8:1]), 32'h01);
      chk("snap high byte", 32'(bits[18:11]), 32'h00);

      // Request at cycle 30 is ignored
      frame4(16'h5A3C, 16'h5A3C, 1, 30, 0, 100, bits, bits2, nbusy, ndone, first_done);
      chk("ignored req done count", 32'(ndone), 32'd1);
      chk("ignored req busy cycles", 32'(nbusy), 32'd80);
      chk("ignored req slots", 32'(bits), 32'(make_frame(16'h5A3C)));

      // Held request: two frames, second starts off the done cycle
      frame4(16'h1234, 16'h1234, 100, 0, 0, 170, bits, bits2, nbusy, ndone, first_done);
      chk("held f1 low", 32'(bits[8:1]), 32'h34);
      chk("held f1 high", 32'(bits[18:11]), 32'h12);
      chk("held f2 low", 32'(bits2[8:1]), 32'h34);
      chk("held f2 high", 32'(bits2[18:11]), 32'h12);
      chk("held done count", 32'(ndone), 32'd2);
      chk("held busy cycles", 32'(nbusy), 32'd160);

      // Reset mid-frame, then a clean frame
      frame4(16'hBEEF, 16'hBEEF, 1, 0, 40, 100, bits, bits2, nbusy, ndone, first_done);
      chk("rst busy cycles", 32'(nbusy), 32'd40);
      chk("rst done count", 32'(ndone), 32'd0);
      frame4(16'hC0DE, 16'hC0DE, 1, 0, 0, 100, bits, bits2, nbusy, ndone, first_done);
      chk("post-rst slots", 32'(bits), 32'h00C0DE ? 32'(make_frame(16'hC0DE)) : 32'd0);
      chk("post-rst done cycle", 32'(first_done), 32'd81);

      // One clock per bit
      seq1 = '0; done1 = 0;
      @(negedge clk);
      stack_v[1] = 16'hFF00;
      req_v[1]   = 1'b1;
      for (int k = 1; k <= 25; k++) begin
         @(negedge clk);
         if (k <= 20) seq1[k - 1] = tx_v[1];
         if (done_v[1] && done1 == 0) done1 = k;
         req_v[1] = 1'b0;
      end
      chk("cpb1 slots", 32'(seq1), 32'h000FFA00);
      chk("cpb1 done cycle", 32'(done1), 32'd21);

      repeat (4) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/vslc_stack_dump.md
# vslc_stack_dump

Debug transmitter that snapshots the VSLC core's 16-bit bit stack and sends it off-chip as two back-to-back UART-style bytes on one output pin. It lets a host read the stack state (tos, nos, hos and deeper entries) without simulator probes. It sits beside the core's execute stage, with its request and status mapped to spare `ui_in`/`uo_out` bits at the top level.

## Interface
Parameters:
- `STACK_W`, 16: stack width in bits. Fixed at 16; two bytes per frame.
- `CLKS_PER_BIT`, 4: clock cycles per serial bit. Must be 1 or more.

Ports:
- `clk` in 1: the single clock; everything in this block is clocked on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `stack_in` in 16: live stack from the core; bit 0 is tos.
- `req` in 1: dump request, level-sampled while idle.
- `tx` out 1: serial output. Idles high.
- `busy` out 1: high while a frame is in flight.
- `done` out 1: one-cycle pulse when a frame completes.

## Operation
- **States:**
  - IDLE
  - START
  - DATA
  - STOP
- **Byte index `byte_sel`:** 0 selects `stack_in[7:0]`; 1 selects `stack_in[15:8]`.
- **IDLE:**
  - On `req`=1, latch `stack_in` into a 16-bit shadow register.
  - Set `byte_sel`=0 and go to START.
  - The core may keep changing the stack; the frame always carries the latched value.
- **START:** drive `tx`=0 for one bit period, then go to DATA with bit index 0.
- **DATA:**
  - Drive `tx` = shadow[`byte_sel`*8 + idx], LSB first, one bit period per bit.
  - After idx 7, go to STOP.
- **STOP:**
  - Drive `tx`=1 for one bit period.
  - If `byte_sel`=0: set `byte_sel`=1 and go directly to START, with no extra idle bit.
  - If `byte_sel`=1: go to IDLE and pulse `done`.
- **Bit period counter:**
  - Counts 0..CLKS_PER_BIT-1 and wraps to 0.
  - Width is clog2(CLKS_PER_BIT), minimum 1 bit.
  - Cleared on every state entry from IDLE.
- **Requests while busy:** `req` during START, DATA or STOP is ignored, not queued.
- **Held request:** if `req` is still high when the block returns to IDLE, a new frame starts on that same IDLE cycle's edge.
- **Reset:**
  - `rst` forces IDLE, `tx`=1, `busy`=0, `done`=0 and clears the counter, regardless of state, including mid-frame.
  - The shadow register resets to 0.
- **Output registering:** `tx`, `busy` and `done` are registered, with no combinational path from inputs.

## Timing
- **Reset values:** `tx`=1, `busy`=0, `done`=0.
- **Request sampling:** `req` is sampled at edge E0.
  - From E0+1 onward, `tx`=0 (start bit) and `busy`=1.
  - Latency from request to first start bit is one cycle.
- **Bit slots:** each of the 20 bit slots lasts exactly CLKS_PER_BIT cycles. A full frame is 20*CLKS_PER_BIT cycles.
- **Frame end:**
  - `busy` is high for exactly 20*CLKS_PER_BIT cycles.
  - On the cycle after the final stop slot, `busy`=0, `done`=1 for exactly one cycle, and `tx`=1.
- **Back-to-back frames:** with `req` held high, the next start bit begins on the cycle `done` is high. `busy` stays 0 for that one cycle only.
- **CLKS_PER_BIT=1:** one bit per cycle; all of the above holds.
- **`rst` mid-frame:** outputs take their reset values at the next edge, and no `done` pulse is emitted.

## Structure
- **Package `vslc_pkg`:**
  - `STACK_W` constant.
  - State enum `dump_state_t` (IDLE/START/DATA/STOP).
  - Byte width constant 8.
- **Sub-module `vslc_baud_tick`:**
  - Parameterised counter with synchronous clear.
  - Outputs a one-cycle `tick` on the last cycle of each bit period.
  - The FSM advances only on `tick`.

## Test plan
Benches use CLKS_PER_BIT=4 unless noted.
- **Basic frame:** `stack_in`=16'hA5C3, pulse `req` one cycle.
  - `tx` per 4-cycle slot: 0, 1,1,0,0,0,0,1,1, 1, 0, 1,0,1,0,0,1,0,1, 1.
  - `busy` high for 80 cycles, `done` pulses at cycle 81, `tx`=1 afterward.
- **Snapshot isolation:** `stack_in`=16'h0001, `req`, then change `stack_in` to 16'hFFFF one cycle later.
  - Data bits decode as 8'h01 then 8'h00.
- **Ignored request:** pulse `req` again at cycle 30 of a frame.
  - Only one frame is sent and only one `done` pulse occurs.
  - `tx` stays high after cycle 80.
- **Held request:** hold `req` high with `stack_in`=16'h1234.
  - Two frames back-to-back; the second start bit begins the cycle `done`=1.
  - Both frames decode to 8'h34 then 8'h12.
- **Reset mid-frame:** assert `rst` for one cycle at cycle 40.
  - Next cycle `tx`=1, `busy`=0, `done`=0, and no `done` follows.
  - A subsequent `req` produces a clean full frame.
- **CLKS_PER_BIT=1:** `stack_in`=16'hFF00.
  - `tx` = 0, eight 0s, 1, 0, eight 1s, 1 on consecutive cycles.
  - `done` on cycle 21.
